// File: rtl/rom_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port plus the decode handshake.
//   rom_addr    : word address driven to the instruction ROM
//   rom_rdata   : ROM read data, registered one cycle after rom_addr
//   instr_valid : head of the fetch buffer is presentable to decode
//   instr_ready : decode accepts the head this cycle
//   instr_data  : instruction word at the head
//   instr_pc    : byte PC of instr_data
//   instr_fault : head came from an out-of-range fetch
interface rom_fetch_unit_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    // Fetch unit side
    modport master (
        output rom_addr,
        input  rom_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output instr_fault
    );

    // ROM / decode side
    modport slave (
        input  rom_addr,
        output rom_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  instr_fault
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues at most one ROM read at a
// time, buffers returned words in a small circular FIFO and hands them to
// decode over valid/ready. A redirect flushes buffered and in-flight work.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : permits new ROM reads
//   redirect_valid  : redirect request (priority over everything else)
//   redirect_pc     : new byte PC, low two bits ignored
//   bus             : ROM read port and decode handshake (master side)
module rom_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_SIZE   = 32768,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    rom_fetch_unit_if.master        bus
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [XLEN-1:0] FAULT_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    // State
    logic [XLEN-1:0]  pc_q,             pc_d;
    logic             inflight_q,       inflight_d;
    logic [XLEN-1:0]  inflight_pc_q,    inflight_pc_d;
    logic             inflight_fault_q, inflight_fault_d;
    logic             fault_stop_q,     fault_stop_d;
    fetch_entry_t     fifo_q [FIFO_DEPTH];
    fetch_entry_t     fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,         wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,         rd_ptr_d;
    logic [CNT_W-1:0] count_q,          count_d;

    // Control
    logic             head_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic             pc_fault;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ROM is word-indexed; the PC register drives it directly
    assign bus.rom_addr = {2'b00, pc_q[31:2]};

    // Head presentation; a redirect suppresses valid so no handshake completes
    assign head_valid      = (count_q != '0);
    assign bus.instr_valid = head_valid & ~redirect_valid;
    assign bus.instr_data  = fifo_q[rd_ptr_q].data;
    assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;
    assign bus.instr_fault = fifo_q[rd_ptr_q].fault;

    // Issue only when a slot is guaranteed for the returning word
    assign pop      = bus.instr_valid & bus.instr_ready;
    assign occ      = OCC_W'(count_q) + OCC_W'(inflight_q);
    assign push     = inflight_q & ~redirect_valid;
    assign pc_fault = ({2'b00, pc_q[31:2]} >= MEM_SIZE);
    assign issue    = fetch_en & ~redirect_valid & ~fault_stop_q &
                      ((occ < OCC_W'(FIFO_DEPTH)) | pop);

    // Next-state logic
    always_comb begin
        pc_d             = pc_q;
        inflight_d       = inflight_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_fault_d = inflight_fault_q;
        fault_stop_d     = fault_stop_q;
        fifo_d           = fifo_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc & ~32'h0000_0003;
            inflight_d   = 1'b0;
            fault_stop_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q].data  = inflight_fault_q ? FAULT_INSTR : bus.rom_rdata;
                fifo_d[wr_ptr_q].pc    = inflight_pc_q;
                fifo_d[wr_ptr_q].fault = inflight_fault_q;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
                inflight_d             = 1'b0;
            end

            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // A new issue at the same edge as a return keeps inflight set
            if (issue) begin
                inflight_d       = 1'b1;
                inflight_pc_d    = pc_q;
                inflight_fault_d = pc_fault;
                pc_d             = pc_q + 32'd4;
                if (pc_fault) begin
                    fault_stop_d = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_fault_q <= 1'b0;
            fault_stop_q     <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q             <= pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_fault_q <= inflight_fault_d;
            fault_stop_q     <= fault_stop_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            fifo_q           <= fifo_d;
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed stimulus with an expected-delivery
// queue per instance, drained by a negedge monitor on every handshake.
// dut_a uses the full ROM size; dut_b uses MEM_SIZE=16 for the fault path.
module tb_rom_fetch_unit;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en_a, redirect_valid_a;
    logic [31:0] redirect_pc_a;
    logic        fetch_en_b, redirect_valid_b;
    logic [31:0] redirect_pc_b;

    rom_fetch_unit_if bus_a ();
    rom_fetch_unit_if bus_b ();

    exp_t q_a [$];
    exp_t q_b [$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rom_fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(32768), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en_a),
        .redirect_valid (redirect_valid_a),
        .redirect_pc    (redirect_pc_a),
        .bus            (bus_a)
    );

    rom_fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(16), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en_b),
        .redirect_valid (redirect_valid_b),
        .redirect_pc    (redirect_pc_b),
        .bus            (bus_b)
    );

    // ROM models: word[i] = i + 100, one-cycle registered read
    always @(posedge clk) begin
        bus_a.rom_rdata <= bus_a.rom_addr + 32'd100;
        bus_b.rom_rdata <= bus_b.rom_addr + 32'd100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        exp_t e;
        e.pc = pc; e.data = data; e.fault = fault;
        q_a.push_back(e);
    endtask

    task automatic expect_b(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        exp_t e;
        e.pc = pc; e.data = data; e.fault = fault;
        q_b.push_back(e);
    endtask

    // Monitor: every completed handshake must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus_a.instr_valid && bus_a.instr_ready) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: got pc %h data %h, expected no delivery", bus_a.instr_pc, bus_a.instr_data);
                end else begin
                    e = q_a.pop_front();
                    check("a_pc", bus_a.instr_pc, e.pc);
                    check("a_data", bus_a.instr_data, e.data);
                    check("a_fault", 32'(bus_a.instr_fault), 32'(e.fault));
                end
            end
            if (bus_b.instr_valid && bus_b.instr_ready) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got pc %h data %h, expected no delivery", bus_b.instr_pc, bus_b.instr_data);
                end else begin
                    e = q_b.pop_front();
                    check("b_pc", bus_b.instr_pc, e.pc);
                    check("b_data", bus_b.instr_data, e.data);
                    check("b_fault", 32'(bus_b.instr_fault), 32'(e.fault));
                end
            end
            // The issue rule must never let a return land in a full FIFO
            check("a_no_full_push", 32'(dut_a.push && (dut_a.count_q == 2'(DEPTH))), 32'd0);
            check("b_no_full_push", 32'(dut_b.push && (dut_b.count_q == 2'(DEPTH))), 32'd0);
        end
    end

    initial begin
        rst_n            = 1'b0;
        fetch_en_a       = 1'b1;
        redirect_valid_a = 1'b0;
        redirect_pc_a    = 32'h0;
        bus_a.instr_ready = 1'b1;
        fetch_en_b       = 1'b0;
        redirect_valid_b = 1'b0;
        redirect_pc_b    = 32'h0;
        bus_b.instr_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus_a.instr_valid), 32'd0);
        check("rst_data", bus_a.instr_data, 32'd0);
        check("rst_pc", bus_a.instr_pc, 32'd0);
        check("rst_fault", 32'(bus_a.instr_fault), 32'd0);
        check("rst_rom_addr", bus_a.rom_addr, 32'd0);

        // Streaming from reset, then fetch_en dropped in cycle 5
        for (int i = 0; i < 5; i++) expect_a(32'(4 * i), 32'(100 + i), 1'b0);
        rst_n = 1'b1;                                      // cycle 0
        check("lat_c0_valid", 32'(bus_a.instr_valid), 32'd0);
        tick();                                            // cycle 1
        check("lat_c1_valid", 32'(bus_a.instr_valid), 32'd0);
        tick();                                            // cycle 2
        check("lat_c2_valid", 32'(bus_a.instr_valid), 32'd1);
        check("lat_c2_pc", bus_a.instr_pc, 32'h0);
        tick(); tick(); tick();                            // cycle 5
        check("stream_c5_valid", 32'(bus_a.instr_valid), 32'd1);
        fetch_en_a = 1'b0;
        tick();                                            // cycle 6: in-flight word
        check("drain_c6_valid", 32'(bus_a.instr_valid), 32'd1);
        check("drain_c6_pc", bus_a.instr_pc, 32'h10);
        tick();                                            // cycle 7
        check("drain_c7_valid", 32'(bus_a.instr_valid), 32'd0);
        check("drain_c7_rom_addr", bus_a.rom_addr, 32'd5);

        // Back-pressure: ready low while the FIFO fills
        tick();                                            // cycle 8
        fetch_en_a = 1'b1;
        bus_a.instr_ready = 1'b0;
        expect_a(32'h14, 32'd105, 1'b0);
        expect_a(32'h18, 32'd106, 1'b0);
        tick(); tick();                                    // cycle 10
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus_a.instr_valid), 32'd1);
            check("hold_data", bus_a.instr_data, 32'd105);
            check("hold_pc", bus_a.instr_pc, 32'h14);
            check("hold_rom_addr", bus_a.rom_addr, 32'd7);
            tick();
        end                                                // cycle 15
        bus_a.instr_ready = 1'b1;
        tick(); tick();                                    // cycle 17: redirect
        redirect_valid_a = 1'b1;
        redirect_pc_a    = 32'h0000_0043;
        #1;
        check("redir_valid_forced", 32'(bus_a.instr_valid), 32'd0);
        expect_a(32'h40, 32'd116, 1'b0);
        expect_a(32'h44, 32'd117, 1'b0);
        tick();                                            // cycle 18
        redirect_valid_a = 1'b0;
        check("redir_c18_valid", 32'(bus_a.instr_valid), 32'd0);
        check("redir_rom_addr", bus_a.rom_addr, 32'h10);
        tick();                                            // cycle 19
        check("redir_c19_valid", 32'(bus_a.instr_valid), 32'd0);
        tick();                                            // cycle 20
        check("redir_c20_valid", 32'(bus_a.instr_valid), 32'd1);
        check("redir_c20_pc", bus_a.instr_pc, 32'h40);
        tick(); tick();                                    // cycle 22
        bus_a.instr_ready = 1'b0;
        tick();                                            // cycle 23: FIFO full
        check("full_valid", 32'(bus_a.instr_valid), 32'd1);
        check("full_pc", bus_a.instr_pc, 32'h48);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus_a.instr_valid), 32'd0);
        check("async_rst_data", bus_a.instr_data, 32'd0);
        check("async_rst_pc", bus_a.instr_pc, 32'd0);
        check("async_rst_fault", 32'(bus_a.instr_fault), 32'd0);
        check("async_rst_rom_addr", bus_a.rom_addr, 32'd0);
        tick();
        bus_a.instr_ready = 1'b1;
        expect_a(32'h0, 32'd100, 1'b0);
        expect_a(32'h4, 32'd101, 1'b0);
        rst_n = 1'b1;                                      // cycle 0
        tick();                                            // cycle 1
        check("restart_c1_valid", 32'(bus_a.instr_valid), 32'd0);
        tick();                                            // cycle 2
        check("restart_c2_valid", 32'(bus_a.instr_valid), 32'd1);
        check("restart_c2_pc", bus_a.instr_pc, 32'h0);
        fetch_en_a = 1'b0;
        tick(); tick();                                    // cycle 4
        check("restart_c4_valid", 32'(bus_a.instr_valid), 32'd0);
        check("restart_rom_addr", bus_a.rom_addr, 32'd2);

        // Out-of-range fetch on dut_b (MEM_SIZE=16) starting at 0x38
        tick();                                            // cycle r
        fetch_en_b       = 1'b1;
        redirect_valid_b = 1'b1;
        redirect_pc_b    = 32'h38;
        expect_b(32'h38, 32'd114, 1'b0);
        expect_b(32'h3C, 32'd115, 1'b0);
        expect_b(32'h40, 32'h0000_0013, 1'b1);
        tick();                                            // r+1
        redirect_valid_b = 1'b0;
        tick(); tick();                                    // r+3
        check("b_first_valid", 32'(bus_b.instr_valid), 32'd1);
        check("b_first_pc", bus_b.instr_pc, 32'h38);
        tick(); tick();                                    // r+5
        check("b_fault_valid", 32'(bus_b.instr_valid), 32'd1);
        check("b_fault_flag", 32'(bus_b.instr_fault), 32'd1);
        check("b_fault_data", bus_b.instr_data, 32'h0000_0013);
        tick();                                            // r+6
        check("b_stop_valid", 32'(bus_b.instr_valid), 32'd0);
        check("b_stop_rom_addr", bus_b.rom_addr, 32'h11);
        tick(); tick();                                    // r+8
        check("b_stop2_valid", 32'(bus_b.instr_valid), 32'd0);
        check("b_stop2_rom_addr", bus_b.rom_addr, 32'h11);
        tick();                                            // r+9: restart at 0
        redirect_valid_b = 1'b1;
        redirect_pc_b    = 32'h0;
        expect_b(32'h0, 32'd100, 1'b0);
        expect_b(32'h4, 32'd101, 1'b0);
        tick();                                            // r+10
        redirect_valid_b = 1'b0;
        tick();                                            // r+11
        check("b_restart_c11_valid", 32'(bus_b.instr_valid), 32'd0);
        tick();                                            // r+12
        check("b_restart_valid", 32'(bus_b.instr_valid), 32'd1);
        check("b_restart_pc", bus_b.instr_pc, 32'h0);
        fetch_en_b = 1'b0;
        tick(); tick();                                    // r+14
        check("b_end_valid", 32'(bus_b.instr_valid), 32'd0);

        tick();
        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
